// File: rtl/dmem_subsystem_if.sv
// Core-side data-memory bus: address, store data and store type in, registered read word out.
interface dmem_subsystem_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AWIDTH = 16
);
  logic [AWIDTH-1:0] data_mem_addr;
  logic [XLEN-1:0]   data_mem_wdata;
  logic [2:0]        data_mem_we;
  logic [XLEN-1:0]   data_mem_out;

  modport master (
    output data_mem_addr,
    output data_mem_wdata,
    output data_mem_we,
    input  data_mem_out
  );

  modport slave (
    input  data_mem_addr,
    input  data_mem_wdata,
    input  data_mem_we,
    output data_mem_out
  );
endinterface

// File: rtl/dmem_subsystem.sv
// Data-memory subsystem: lane-masked byte RAM, GPIO register and prescaled 64-bit
// machine timer with compare interrupt, all behind one registered read port.
module dmem_subsystem #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned RAM_WORDS = 4096,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmem_subsystem_if.slave        bus,
  output logic [7:0]             gpio_out,
  output logic                   timer_irq,
  output logic                   misalign_err
);

  localparam int unsigned NLANES = XLEN / 8;
  localparam int unsigned IDX_W  = $clog2(RAM_WORDS);
  localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] WE_SB = 3'b001;
  localparam logic [2:0] WE_SH = 3'b010;
  localparam logic [2:0] WE_SW = 3'b100;

  localparam logic [7:0] OFF_GPIO   = 8'h00;
  localparam logic [7:0] OFF_MTIME_L = 8'h04;
  localparam logic [7:0] OFF_MTIME_H = 8'h08;
  localparam logic [7:0] OFF_CMP_L  = 8'h0C;
  localparam logic [7:0] OFF_CMP_H  = 8'h10;

  logic [XLEN-1:0]   mem [RAM_WORDS];
  logic [PS_W-1:0]   prescaler;
  logic [63:0]       mtime;
  logic [63:0]       mtimecmp;

  logic              sel_mmio_c;
  logic [7:0]        off_c;
  logic [IDX_W-1:0]  ram_idx_c;
  logic              is_sb_c, is_sh_c, is_sw_c;
  logic              sh_ok_c, sw_ok_c;
  logic              ram_wr_c, mmio_wr_c, misalign_c;
  logic [NLANES-1:0] lane_en_c;
  logic [XLEN-1:0]   lane_data_c;
  logic [XLEN-1:0]   rdata_c;
  logic              wrap_c;
  logic              unused_c;

  assign sel_mmio_c = bus.data_mem_addr[AWIDTH-1];
  assign off_c      = bus.data_mem_addr[7:0];
  // Word index wraps modulo RAM_WORDS by keeping only the low index bits
  assign ram_idx_c  = bus.data_mem_addr[IDX_W+1:2];
  assign unused_c   = ^bus.data_mem_addr;

  assign is_sb_c = (bus.data_mem_we == WE_SB);
  assign is_sh_c = (bus.data_mem_we == WE_SH);
  assign is_sw_c = (bus.data_mem_we == WE_SW);
  assign sh_ok_c = ~bus.data_mem_addr[0];
  assign sw_ok_c = (bus.data_mem_addr[1:0] == 2'b00);

  assign ram_wr_c   = ~sel_mmio_c & (is_sb_c | (is_sh_c & sh_ok_c) | (is_sw_c & sw_ok_c));
  assign mmio_wr_c  = sel_mmio_c & is_sw_c & sw_ok_c;
  // Sub-word stores to MMIO are silently dropped, so only SW counts as misaligned there
  assign misalign_c = (is_sh_c & ~sh_ok_c & ~sel_mmio_c) | (is_sw_c & ~sw_ok_c);

  // Lane enables and store data replicated across lanes so any lane can pick its byte
  always_comb begin
    lane_en_c   = '0;
    lane_data_c = bus.data_mem_wdata;
    if (is_sb_c) begin
      lane_en_c   = NLANES'(4'b0001 << bus.data_mem_addr[1:0]);
      lane_data_c = {NLANES{bus.data_mem_wdata[7:0]}};
    end else if (is_sh_c) begin
      lane_en_c   = NLANES'(4'b0011 << {bus.data_mem_addr[1], 1'b0});
      lane_data_c = {(NLANES/2){bus.data_mem_wdata[15:0]}};
    end else if (is_sw_c) begin
      lane_en_c   = '1;
    end
  end

  // RAM array has no reset; a store coinciding with reset is suppressed
  always_ff @(posedge clk) begin
    if (rst_n && ram_wr_c) begin
      for (int i = 0; i < int'(NLANES); i++) begin
        if (lane_en_c[i]) mem[ram_idx_c][i*8 +: 8] <= lane_data_c[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (!sel_mmio_c) begin
      rdata_c = mem[ram_idx_c];
    end else begin
      case (off_c)
        OFF_GPIO:    rdata_c = XLEN'(gpio_out);
        OFF_MTIME_L: rdata_c = XLEN'(mtime[31:0]);
        OFF_MTIME_H: rdata_c = XLEN'(mtime[63:32]);
        OFF_CMP_L:   rdata_c = XLEN'(mtimecmp[31:0]);
        OFF_CMP_H:   rdata_c = XLEN'(mtimecmp[63:32]);
        default:     rdata_c = '0;
      endcase
    end
  end

  assign wrap_c = (prescaler == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_mem_out <= '0;
      gpio_out         <= '0;
      prescaler        <= '0;
      mtime            <= '0;
      mtimecmp         <= '1;
      timer_irq        <= 1'b0;
      misalign_err     <= 1'b0;
    end else begin
      bus.data_mem_out <= rdata_c;
      prescaler        <= wrap_c ? '0 : prescaler + PS_W'(1);
      timer_irq        <= (mtime >= mtimecmp);
      misalign_err     <= misalign_err | misalign_c;

      // A software write to either mtime half replaces the tick for that cycle
      if (mmio_wr_c && off_c == OFF_MTIME_L) begin
        mtime[31:0] <= bus.data_mem_wdata[31:0];
      end else if (mmio_wr_c && off_c == OFF_MTIME_H) begin
        mtime[63:32] <= bus.data_mem_wdata[31:0];
      end else if (wrap_c) begin
        mtime <= mtime + 64'd1;
      end

      if (mmio_wr_c && off_c == OFF_CMP_L) mtimecmp[31:0]  <= bus.data_mem_wdata[31:0];
      if (mmio_wr_c && off_c == OFF_CMP_H) mtimecmp[63:32] <= bus.data_mem_wdata[31:0];
      if (mmio_wr_c && off_c == OFF_GPIO)  gpio_out        <= bus.data_mem_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_dmem_subsystem.sv
// Directed bench for dmem_subsystem: expected read words are queued as each access is
// driven and checked one clock later; side outputs are checked at fixed points.
module tb_dmem_subsystem;

  localparam logic [2:0] SB = 3'b001;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SW = 3'b100;
  localparam logic [2:0] NO = 3'b000;

  typedef struct {
    bit          en;
    logic [31:0] v;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [7:0] gpio_out;
  logic timer_irq;
  logic misalign_err;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_q[$];

  dmem_subsystem_if #(.XLEN(32), .AWIDTH(16)) bus ();

  dmem_subsystem #(
    .XLEN(32), .AWIDTH(16), .RAM_WORDS(4096), .PRESCALE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .gpio_out(gpio_out),
    .timer_irq(timer_irq),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access for one clock; the queued expectation is the read result of this access
  task automatic step(input logic [15:0] a, input logic [31:0] d, input logic [2:0] w,
                      input bit en, input logic [31:0] exp, input string tag);
    exp_t e;
    bus.data_mem_addr  = a;
    bus.data_mem_wdata = d;
    bus.data_mem_we    = w;
    e.en = en; e.v = exp; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.en) check(e.tag, bus.data_mem_out, e.v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.data_mem_addr  = '0;
    bus.data_mem_wdata = '0;
    bus.data_mem_we    = NO;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",  bus.data_mem_out, 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_irq",  32'(timer_irq), 32'h0);
    check("rst_err",  32'(misalign_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timer: mtimecmp = 3; mtime ticks on edges 4, 8, 12 after release
    step(16'h8010, 32'h0, SW, 1, 32'hFFFF_FFFF, "cmp_hi_rd");
    step(16'h800C, 32'h3, SW, 1, 32'hFFFF_FFFF, "cmp_lo_rd");
    for (int k = 3; k <= 12; k++) step(16'h8004, 32'h0, NO, 1, 32'((k - 1) / 4), "mtime_rd");
    check("irq_before", 32'(timer_irq), 32'h0);
    step(16'h8004, 32'h0, NO, 1, 32'h3, "mtime_at_irq");
    check("irq_rise", 32'(timer_irq), 32'h1);
    step(16'h800C, 32'd100, SW, 1, 32'h3, "cmp_lo_old");
    check("irq_hold", 32'(timer_irq), 32'h1);
    step(16'h8004, 32'h0, NO, 1, 32'h3, "mtime_rd15");
    check("irq_fall", 32'(timer_irq), 32'h0);

    // Byte store into a word
    step(16'h0000, 32'h1122_3344, SW, 0, 32'h0, "sw0");
    step(16'h0002, 32'h0000_00AA, SB, 1, 32'h1122_3344, "sb_old");
    step(16'h0000, 32'h0, NO, 1, 32'h11AA_3344, "sb_lane2");

    // Halfword store, then misaligned word store
    step(16'h0004, 32'h0, SW, 0, 32'h0, "sw4");
    step(16'h0006, 32'h0000_BEEF, SH, 1, 32'h0, "sh_old");
    step(16'h0004, 32'h0, NO, 1, 32'hBEEF_0000, "sh_upper");
    check("err_clear", 32'(misalign_err), 32'h0);
    step(16'h0005, 32'hFFFF_FFFF, SW, 1, 32'hBEEF_0000, "mis_sw_rd");
    step(16'h0004, 32'h0, NO, 1, 32'hBEEF_0000, "mis_sw_drop");
    check("err_set", 32'(misalign_err), 32'h1);
    step(16'h0007, 32'h0000_1234, SH, 1, 32'hBEEF_0000, "mis_sh_rd");
    step(16'h0004, 32'h0, NO, 1, 32'hBEEF_0000, "mis_sh_drop");

    // Read-first on same-word write
    step(16'h0010, 32'h5, SW, 0, 32'h0, "sw10_5");
    step(16'h0010, 32'h9, SW, 1, 32'h5, "raw_old");
    step(16'h0010, 32'h0, NO, 1, 32'h9, "raw_new");

    // RAM index wraps modulo RAM_WORDS: 0x4000 aliases word 0
    step(16'h4000, 32'h0000_CAFE, SW, 1, 32'h11AA_3344, "alias_rd");
    step(16'h0000, 32'h0, NO, 1, 32'h0000_CAFE, "alias_wr");

    // GPIO and unmapped MMIO
    step(16'h8000, 32'h1234_56A5, SW, 1, 32'h0, "gpio_old");
    check("gpio_set", 32'(gpio_out), 32'hA5);
    step(16'h8000, 32'h0, SB, 1, 32'h0000_00A5, "gpio_rd");
    check("gpio_sb_drop", 32'(gpio_out), 32'hA5);
    check("err_mmio_sb", 32'(misalign_err), 32'h1);
    step(16'h8020, 32'hDEAD_BEEF, SW, 1, 32'h0, "unmapped_rd");
    step(16'h8008, 32'h5, SW, 1, 32'h0, "mtime_hi_old");
    step(16'h8008, 32'h0, NO, 1, 32'h5, "mtime_hi_wr");

    // Lower mtimecmp to 0 so the interrupt is asserted before reset
    step(16'h8010, 32'h0, SW, 0, 32'h0, "cmp_hi0");
    step(16'h800C, 32'h0, SW, 0, 32'h0, "cmp_lo0");
    step(16'h8004, 32'h0, NO, 0, 32'h0, "idle");
    check("irq_pre_rst", 32'(timer_irq), 32'h1);
    bus.data_mem_we = NO;

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gpio", 32'(gpio_out), 32'h0);
    check("arst_irq",  32'(timer_irq), 32'h0);
    check("arst_err",  32'(misalign_err), 32'h0);
    check("arst_out",  bus.data_mem_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h8004, 32'h0, NO, 1, 32'h0, "post_mtime_lo");
    step(16'h8008, 32'h0, NO, 1, 32'h0, "post_mtime_hi");
    step(16'h800C, 32'h0, NO, 1, 32'hFFFF_FFFF, "post_cmp_lo");
    step(16'h8000, 32'h0, NO, 1, 32'h0, "post_gpio");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
